// File: rtl/floppy_pkg.sv
// Shared types and constants for the floppy read-path byte stream.
package floppy_pkg;

  localparam logic [15:0] CRC_POLY     = 16'h1021;
  localparam logic [15:0] CRC_IDAM_PRE = 16'hB230;  // CRC of A1 A1 A1 FE from 0xFFFF
  localparam logic [15:0] CRC_DAM_PRE  = 16'hE295;  // CRC of A1 A1 A1 FB from 0xFFFF

  typedef enum logic [1:0] {
    GAP  = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    NONE = 2'd3
  } field_state_t;

  // One byte travelling down the strobe -> read -> output pipe.
  typedef struct packed {
    logic       valid;
    logic       data;   // byte comes from the sector buffer, not from val
    logic       first;
    logic       last;   // final data byte of the field
    logic [7:0] val;
  } stream_slot_t;

  // ID-field size code; unsupported lengths fall back to the 512-byte code.
  function automatic logic [7:0] size_code(input logic [10:0] sector_len);
    case (sector_len)
      11'd128:  size_code = 8'd0;
      11'd256:  size_code = 8'd1;
      11'd512:  size_code = 8'd2;
      11'd1024: size_code = 8'd3;
      default:  size_code = 8'd2;
    endcase
  endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Combinational CRC-CCITT (0x1021, MSB first) advance by one whole byte.
module crc16_ccitt_byte
  import floppy_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc
);

  logic [15:0] w_c;

  // Eight bit-serial steps unrolled into one combinational stage.
  always_comb begin
    w_c = i_crc;
    for (int i = 7; i >= 0; i--) begin
      if (w_c[15] ^ i_data[i]) begin
        w_c = (w_c << 1) ^ CRC_POLY;
      end else begin
        w_c = w_c << 1;
      end
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/floppy_field_stream.sv
// Turns drive sector timing into the FDC read-path byte stream: ID field bytes
// plus CRC, and data field bytes fetched from the sector buffer.
module floppy_field_stream
  import floppy_pkg::*;
#(
  parameter logic SECTOR_BASE_DEF = 1'b1,
  parameter int   RD_LAT          = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dclk_en,
  input  logic        sector_hdr,
  input  logic        sector_data,
  input  logic [6:0]  track,
  input  logic [4:0]  sector,
  input  logic        side,
  input  logic [10:0] sector_len,
  input  logic        sector_base,
  output logic [4:0]  buff_sector,
  output logic [9:0]  buff_addr,
  output logic        buff_rd,
  input  logic [7:0]  buff_din,
  output logic [7:0]  dout,
  output logic        dout_strobe,
  output logic        dout_hdr,
  output logic        dout_first,
  output logic [15:0] data_crc,
  output logic        data_crc_valid
);

  logic [15:0]  r_crc;
  logic [10:0]  r_idx;
  logic         r_synced;
  field_state_t r_prev;
  logic [4:0]   r_sector;
  logic         r_base;
  stream_slot_t r_s1;
  stream_slot_t r_s2;

  field_state_t w_state;
  logic         w_start;
  logic [10:0]  w_idx;
  logic [15:0]  w_crc_base;
  logic [15:0]  w_crc_hdr_next;
  logic [15:0]  w_crc_data_next;
  logic [7:0]   w_hbyte;
  logic         w_emit_hdr;
  logic         w_emit_data;
  stream_slot_t w_s1;

  // Classify the drive position; ID field wins if both flags are up.
  always_comb begin
    if (sector_hdr) begin
      w_state = HDR;
    end else if (sector_data) begin
      w_state = DATA;
    end else begin
      w_state = GAP;
    end
  end

  assign w_start    = (w_state != r_prev) && (w_state != GAP);
  assign w_idx      = w_start ? 11'd0 : ((&r_idx) ? r_idx : r_idx + 11'd1);
  assign w_crc_base = !w_start ? r_crc :
                      (w_state == HDR) ? CRC_IDAM_PRE : CRC_DAM_PRE;

  // ID field byte for the current index; bytes 4/5 read the CRC over 0..3.
  always_comb begin
    w_hbyte = 8'h00;
    case (w_idx)
      11'd0:   w_hbyte = {1'b0, track};
      11'd1:   w_hbyte = {7'b0, side};
      11'd2:   w_hbyte = {3'b0, sector};
      11'd3:   w_hbyte = size_code(sector_len);
      11'd4:   w_hbyte = w_crc_base[15:8];
      11'd5:   w_hbyte = w_crc_base[7:0];
      default: w_hbyte = 8'h00;
    endcase
  end

  assign w_emit_hdr  = dclk_en && r_synced && (w_state == HDR) && (w_idx <= 11'd5);
  assign w_emit_data = dclk_en && r_synced && (w_state == DATA) && (w_idx < sector_len);

  // Pipe slot launched by this strobe.
  always_comb begin
    w_s1       = '0;
    w_s1.valid = w_emit_hdr || w_emit_data;
    w_s1.data  = w_emit_data;
    w_s1.first = (w_idx == 11'd0);
    w_s1.last  = w_emit_data && (w_idx == sector_len - 11'd1);
    w_s1.val   = w_hbyte;
  end

  crc16_ccitt_byte u_crc_hdr (
    .i_crc  (w_crc_base),
    .i_data (w_hbyte),
    .o_crc  (w_crc_hdr_next)
  );

  crc16_ccitt_byte u_crc_data (
    .i_crc  (r_crc),
    .i_data (buff_din),
    .o_crc  (w_crc_data_next)
  );

  assign buff_sector = r_sector - {4'b0, r_base};

  // Field tracking and the running CRC. ID bytes fold in at strobe time, data
  // bytes when they return from the buffer; strobe spacing keeps these apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_synced <= 1'b0;
      r_prev   <= NONE;
      r_idx    <= 11'd0;
      r_crc    <= 16'hFFFF;
      r_sector <= {4'b0, SECTOR_BASE_DEF};
      r_base   <= SECTOR_BASE_DEF;
    end else if (dclk_en) begin
      r_prev <= w_state;
      r_idx  <= w_idx;
      if (w_state == GAP) begin
        r_synced <= 1'b1;
      end
      if (w_start) begin
        r_sector <= sector;
        r_base   <= sector_base;
      end
      if ((w_state == HDR) && (w_idx <= 11'd3)) begin
        r_crc <= w_crc_hdr_next;
      end else if (w_start) begin
        r_crc <= w_crc_base;
      end
    end else if (r_s2.valid && r_s2.data) begin
      r_crc <= w_crc_data_next;
    end
  end

  // Stage 1: issue the buffer read and capture the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= '0;
      buff_rd   <= 1'b0;
      buff_addr <= 10'd0;
    end else begin
      r_s1    <= w_s1;
      buff_rd <= w_emit_data;
      if (w_emit_data) begin
        buff_addr <= w_idx[9:0];
      end
    end
  end

  // Stage 2 waits out the buffer read; only a one-cycle read is implemented,
  // any other latency leaves the output path idle.
  if (RD_LAT == 1) begin : g_rd_lat1
    always_ff @(posedge clk) begin
      if (reset) begin
        r_s2 <= '0;
      end else begin
        r_s2 <= r_s1;
      end
    end
  end else begin : g_rd_lat_unsupported
    assign r_s2 = '0;
  end

  // Stage 3: registered stream outputs and end-of-field data CRC report.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout           <= 8'h00;
      dout_strobe    <= 1'b0;
      dout_hdr       <= 1'b0;
      dout_first     <= 1'b0;
      data_crc       <= 16'h0000;
      data_crc_valid <= 1'b0;
    end else begin
      dout_strobe    <= r_s2.valid;
      dout_hdr       <= r_s2.valid && !r_s2.data;
      dout_first     <= r_s2.valid && r_s2.first;
      data_crc_valid <= r_s2.valid && r_s2.last;
      if (r_s2.valid) begin
        dout <= r_s2.data ? buff_din : r_s2.val;
      end
      if (r_s2.valid && r_s2.last) begin
        data_crc <= w_crc_data_next;
      end
    end
  end

endmodule
